// File: rtl/sprite_pkg.sv
// Shared sprite types and screen constants for the collision and position blocks.
package sprite_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned HP_W    = 4;
  localparam int unsigned HITS_W  = 8;
  localparam int unsigned FRAME_W = 8;

  localparam int unsigned X_MAX = 639;
  localparam int unsigned Y_MAX = 479;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    ARMED  = 3'd0,
    HIT    = 3'd1,
    INVULN = 3'd2,
    CLEAR  = 3'd3,
    DEAD   = 3'd4
  } hit_state_t;

endpackage

// File: rtl/box_overlap.sv
// Axis-aligned overlap of two square boxes given by centre and half-size.
// Touching edges do not count as overlap.
module box_overlap
  import sprite_pkg::*;
(
  input  coord_t a_x,
  input  coord_t a_y,
  input  coord_t a_s,
  input  coord_t b_x,
  input  coord_t b_y,
  input  coord_t b_s,
  output logic   overlap
);

  logic signed [COORD_W:0] dx;
  logic signed [COORD_W:0] dy;
  logic        [COORD_W:0] abs_dx;
  logic        [COORD_W:0] abs_dy;
  logic        [COORD_W:0] reach;

  // One extra bit keeps both the signed difference and the half-size sum from wrapping.
  always_comb begin
    dx      = $signed({1'b0, a_x}) - $signed({1'b0, b_x});
    dy      = $signed({1'b0, a_y}) - $signed({1'b0, b_y});
    abs_dx  = dx[COORD_W] ? $unsigned(-dx) : $unsigned(dx);
    abs_dy  = dy[COORD_W] ? $unsigned(-dy) : $unsigned(dy);
    reach   = {1'b0, a_s} + {1'b0, b_s};
    overlap = (abs_dx < reach) && (abs_dy < reach);
  end

endmodule

// File: rtl/missile_hit_detect.sv
// Missile/target collision stage with hit handshake, hit points and immunity window.
// Build option: MISSILE_HIT_INVULN_EN selects a timed INVULN window; otherwise CLEAR waits for overlap to end.
module missile_hit_detect
  import sprite_pkg::*;
#(
  parameter int unsigned HP_INIT       = 3,
  parameter int unsigned INVULN_FRAMES = 30
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic [COORD_W-1:0] MissileX,
  input  logic [COORD_W-1:0] MissileY,
  input  logic [COORD_W-1:0] MissileS,
  input  logic               MissileActive,
  input  logic [COORD_W-1:0] TargetX,
  input  logic [COORD_W-1:0] TargetY,
  input  logic [COORD_W-1:0] TargetS,
  input  logic               hit_ack,
  output logic               hit_valid,
  output logic [HP_W-1:0]    target_hp,
  output logic               target_dead,
  output logic               invuln,
  output logic [HITS_W-1:0]  hit_count
);

  if (HP_INIT < 1 || HP_INIT > 15 || INVULN_FRAMES < 1 || INVULN_FRAMES > 255) begin : g_param_check
    $error("missile_hit_detect: HP_INIT or INVULN_FRAMES out of range");
  end

  logic box_hit;
  logic overlap;

  box_overlap u_box_overlap (
    .a_x     (MissileX),
    .a_y     (MissileY),
    .a_s     (MissileS),
    .b_x     (TargetX),
    .b_y     (TargetY),
    .b_s     (TargetS),
    .overlap (box_hit)
  );

  assign overlap = MissileActive & box_hit;

  hit_state_t        state_q, state_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic [HITS_W-1:0] hits_q, hits_d;
  logic              hit_valid_q, hit_valid_d;
  logic              invuln_q, invuln_d;
  logic              dead_q, dead_d;
`ifdef MISSILE_HIT_INVULN_EN
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
`endif

  // Next state; outputs are decoded from the next state so they register with it.
  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    hits_d  = hits_q;
`ifdef MISSILE_HIT_INVULN_EN
    frame_cnt_d = frame_cnt_q;
`endif
    unique case (state_q)
      ARMED: begin
        if (overlap) begin
          state_d = HIT;
          if (hp_q != '0) hp_d = hp_q - HP_W'(1);
        end
      end
      HIT: begin
        if (hit_ack) begin
          if (hits_q != '1) hits_d = hits_q + HITS_W'(1);
          if (hp_q != '0) begin
`ifdef MISSILE_HIT_INVULN_EN
            state_d     = INVULN;
            frame_cnt_d = FRAME_W'(INVULN_FRAMES);
`else
            state_d = CLEAR;
`endif
          end else begin
            state_d = DEAD;
          end
        end
      end
`ifdef MISSILE_HIT_INVULN_EN
      INVULN: begin
        // Loaded with INVULN_FRAMES, leaves on the frame it would reach 0.
        frame_cnt_d = frame_cnt_q - FRAME_W'(1);
        if (frame_cnt_q <= FRAME_W'(1)) begin
          state_d     = ARMED;
          frame_cnt_d = '0;
        end
      end
`else
      CLEAR: begin
        if (!overlap) state_d = ARMED;
      end
`endif
      DEAD: begin
        state_d = DEAD;
      end
      default: begin
        state_d = ARMED;
      end
    endcase

    hit_valid_d = (state_d == HIT);
    invuln_d    = (state_d == INVULN) || (state_d == CLEAR);
    dead_d      = (state_d == DEAD);
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q     <= ARMED;
      hp_q        <= HP_W'(HP_INIT);
      hits_q      <= '0;
      hit_valid_q <= 1'b0;
      invuln_q    <= 1'b0;
      dead_q      <= 1'b0;
`ifdef MISSILE_HIT_INVULN_EN
      frame_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hp_q        <= hp_d;
      hits_q      <= hits_d;
      hit_valid_q <= hit_valid_d;
      invuln_q    <= invuln_d;
      dead_q      <= dead_d;
`ifdef MISSILE_HIT_INVULN_EN
      frame_cnt_q <= frame_cnt_d;
`endif
    end
  end

  assign hit_valid   = hit_valid_q;
  assign target_hp   = hp_q;
  assign target_dead = dead_q;
  assign invuln      = invuln_q;
  assign hit_count   = hits_q;

endmodule

// File: tb/tb_missile_hit_detect.sv
// Randomized self-checking bench for missile_hit_detect against a frame-level game model.
module tb_missile_hit_detect;

  localparam int unsigned HP = 3;
  localparam int unsigned NF = 30;
`ifdef MISSILE_HIT_INVULN_EN
  localparam bit TIMED = 1'b1;
`else
  localparam bit TIMED = 1'b0;
`endif

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1;
  logic [9:0] MissileX = '0, MissileY = '0, MissileS = '0;
  logic [9:0] TargetX = '0, TargetY = '0, TargetS = '0;
  logic       MissileActive = 1'b0;
  logic       hit_ack = 1'b0;
  logic       hit_valid, target_dead, invuln;
  logic [3:0] target_hp;
  logic [7:0] hit_count;

  missile_hit_detect #(.HP_INIT(HP), .INVULN_FRAMES(NF)) dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .MissileX      (MissileX),
    .MissileY      (MissileY),
    .MissileS      (MissileS),
    .MissileActive (MissileActive),
    .TargetX       (TargetX),
    .TargetY       (TargetY),
    .TargetS       (TargetS),
    .hit_ack       (hit_ack),
    .hit_valid     (hit_valid),
    .target_hp     (target_hp),
    .target_dead   (target_dead),
    .invuln        (invuln),
    .hit_count     (hit_count)
  );

  always #5 frame_clk = ~frame_clk;

  int n_pass = 0;
  int n_total = 0;

  // Game-level model: a pending hit, hit points, total hits, immunity frames left, clearing flag, dead flag.
  bit m_pend, m_dead, m_clear;
  int m_hp, m_hits, m_left;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic bit ref_overlap();
    int dx, dy, lim;
    dx  = int'(MissileX) - int'(TargetX);
    dy  = int'(MissileY) - int'(TargetY);
    lim = int'(MissileS) + int'(TargetS);
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    return MissileActive && (dx < lim) && (dy < lim);
  endfunction

  task automatic model_edge();
    bit ov;
    ov = ref_overlap();
    if (Reset) begin
      m_pend = 0; m_dead = 0; m_clear = 0; m_hp = HP; m_hits = 0; m_left = 0;
    end else if (m_dead) begin
      // destroyed target ignores everything
    end else if (m_pend) begin
      if (hit_ack) begin
        m_pend = 0;
        if (m_hits < 255) m_hits++;
        if (m_hp > 0) begin
          if (TIMED) m_left = NF;
          else m_clear = 1;
        end else begin
          m_dead = 1;
        end
      end
    end else if (m_left > 0) begin
      m_left--;
    end else if (m_clear) begin
      if (!ov) m_clear = 0;
    end else if (ov) begin
      m_pend = 1;
      if (m_hp > 0) m_hp--;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge frame_clk);
    #1;
    check_eq("hit_valid", int'(hit_valid), int'(m_pend));
    check_eq("target_hp", int'(target_hp), m_hp);
    check_eq("target_dead", int'(target_dead), int'(m_dead));
    check_eq("invuln", int'(invuln), int'(m_left > 0 || m_clear));
    check_eq("hit_count", int'(hit_count), m_hits);
  endtask

  task automatic place(input int mx, input int my, input int ms,
                       input int tx, input int ty, input int ts);
    MissileX = 10'(mx); MissileY = 10'(my); MissileS = 10'(ms);
    TargetX  = 10'(tx); TargetY  = 10'(ty); TargetS  = 10'(ts);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  initial begin
    do_reset();
    do_reset();

    // Approach from 20 px away; dx=12 touches, dx=11 hits.
    MissileActive = 1'b1;
    place(300, 240, 4, 320, 240, 8); step();
    place(308, 240, 4, 320, 240, 8); step();
    place(309, 240, 4, 320, 240, 8); step();
    repeat (5) step();
    hit_ack = 1'b1; step();
    hit_ack = 1'b0;
    repeat (NF + 3) step();
    place(200, 240, 4, 320, 240, 8);
    repeat (3) step();
    place(315, 236, 4, 320, 240, 8);
    repeat (3) step();

    // Near X=0 the difference must not wrap.
    do_reset();
    place(12, 100, 4, 0, 100, 8); step();
    place(11, 100, 4, 0, 100, 8); step();
    do_reset();
    place(5, 100, 4, 0, 100, 8); step();
    do_reset();
    place(0, 100, 4, 12, 100, 8); step();
    place(1023, 100, 4, 0, 100, 8); step();
    MissileActive = 1'b0;
    place(320, 240, 4, 320, 240, 8); step();
    MissileActive = 1'b1;

    // Overlap and ack held until the target dies, then stays dead until reset.
    hit_ack = 1'b1;
    repeat (3 * (NF + 4)) step();
    MissileActive = 1'b0; step();
    MissileActive = 1'b1; repeat (4) step();
    hit_ack = 1'b0;
    do_reset();
    step();

    // Reset in the middle of a hit and of the immunity window.
    place(320, 240, 4, 320, 240, 8); step();
    Reset = 1'b1; step(); Reset = 1'b0; step();
    hit_ack = 1'b1; step(); hit_ack = 1'b0;
    repeat (3) step();
    Reset = 1'b1; step(); Reset = 1'b0;
    step(); step();

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0)
        place(int'(MissileX), int'(MissileY), int'(MissileS),
              int'($urandom_range(30, 600)), int'($urandom_range(30, 450)), int'($urandom_range(1, 15)));
      if ($urandom_range(0, 39) == 0) begin
        MissileX = 10'($urandom); MissileY = TargetY; MissileS = 10'($urandom_range(0, 20));
        TargetX  = 10'($urandom_range(0, 8));
      end else if ($urandom_range(0, 2) != 0) begin
        MissileX = 10'(int'(TargetX) + int'($urandom_range(0, 48)) - 24);
        MissileY = 10'(int'(TargetY) + int'($urandom_range(0, 48)) - 24);
        MissileS = 10'($urandom_range(0, 10));
      end
      MissileActive = ($urandom_range(0, 7) != 0);
      hit_ack       = ($urandom_range(0, 2) == 0);
      Reset         = ($urandom_range(0, 119) == 0);
      step();
    end
    Reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
